// File: rtl/truth_table_sweeper_if.sv
// Stream bundle for the truth-table sweeper.
// Master drives rows and results; slave drives tables, start, ready.
`timescale 1ns/1ps
interface truth_table_sweeper_if #(
  parameter int N = 3
);
  localparam int ROWS = 2 ** N;

  logic            start;
  logic [ROWS-1:0] tt_dut;
  logic [ROWS-1:0] tt_ref;
  logic            row_ready;
  logic            busy;
  logic            row_valid;
  logic [N-1:0]    row_idx;
  logic            row_s;
  logic            row_ref;
  logic [N:0]      ones_count;
  logic [N:0]      mismatch_count;
  logic [N-1:0]    first_mm_idx;
  logic            any_mismatch;
  logic            done;

  modport master (
    input  start, tt_dut, tt_ref, row_ready,
    output busy, row_valid, row_idx, row_s, row_ref,
    output ones_count, mismatch_count, first_mm_idx,
    output any_mismatch, done
  );

  modport slave (
    output start, tt_dut, tt_ref, row_ready,
    input  busy, row_valid, row_idx, row_s, row_ref,
    input  ones_count, mismatch_count, first_mm_idx,
    input  any_mismatch, done
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every row of an N-input truth table over a valid/ready stream,
// counting minterms and mismatches against a reference table.
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int N = 3
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.master sw
);
  localparam int ROWS = 2 ** N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ROWS-1:0] dut_q, dut_d;
  logic [ROWS-1:0] ref_q, ref_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [N-1:0]    first_q, first_d;
  logic [N:0]      ones_q, ones_d;
  logic [N:0]      mm_q, mm_d;
  logic            any_q, any_d;

  logic s_bit;
  logic r_bit;
  logic accept;
  logic last;

  assign s_bit  = dut_q[idx_q];
  assign r_bit  = ref_q[idx_q];
  assign accept = (state_q == S_SWEEP) && sw.row_ready;
  assign last   = (idx_q == N'(ROWS - 1));

  // Next-state: latch on start, accumulate per accepted row.
  always_comb begin
    state_d = state_q;
    dut_d   = dut_q;
    ref_d   = ref_q;
    idx_d   = idx_q;
    first_d = first_q;
    ones_d  = ones_q;
    mm_d    = mm_q;
    any_d   = any_q;
    unique case (state_q)
      S_IDLE: begin
        if (sw.start) begin
          dut_d   = sw.tt_dut;
          ref_d   = sw.tt_ref;
          idx_d   = '0;
          first_d = '0;
          ones_d  = '0;
          mm_d    = '0;
          any_d   = 1'b0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (accept) begin
          ones_d = ones_q + (N+1)'(s_bit);
          if (s_bit != r_bit) begin
            mm_d  = mm_q + (N+1)'(1);
            any_d = 1'b1;
            if (!any_q) first_d = idx_q;
          end
          // Final row parks the index; no wrap while valid.
          if (last) state_d = S_DONE;
          else      idx_d   = idx_q + N'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous abort to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dut_q   <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
      first_q <= '0;
      ones_q  <= '0;
      mm_q    <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dut_q   <= dut_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      ones_q  <= ones_d;
      mm_q    <= mm_d;
      any_q   <= any_d;
    end
  end

  assign sw.busy           = (state_q != S_IDLE);
  assign sw.row_valid      = (state_q == S_SWEEP);
  assign sw.done           = (state_q == S_DONE);
  assign sw.row_idx        = idx_q;
  assign sw.row_s          = s_bit;
  assign sw.row_ref        = r_bit;
  assign sw.ones_count     = ones_q;
  assign sw.mismatch_count = mm_q;
  assign sw.first_mm_idx   = first_q;
  assign sw.any_mismatch   = any_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: popcount-based model plus
// hand-computed pins for N=3, N=1 and N=4 instances.
`timescale 1ns/1ps
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N(3)) b3();
  truth_table_sweeper_if #(.N(1)) b1();
  truth_table_sweeper_if #(.N(4)) b4();

  truth_table_sweeper #(.N(3)) u3 (
    .clk(clk), .rst(rst), .sw(b3.master));
  truth_table_sweeper #(.N(1)) u1 (
    .clk(clk), .rst(rst), .sw(b1.master));
  truth_table_sweeper #(.N(4)) u4 (
    .clk(clk), .rst(rst), .sw(b4.master));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int popc(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [7:0] mask(input int acc);
    int m;
    m = (1 << acc) - 1;
    return m[7:0];
  endfunction

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Model of the N=3 instance: tables, rows accepted, phase.
  logic [7:0] m_dut = '0;
  logic [7:0] m_ref = '0;
  int m_acc = 0;
  int m_ph  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dut <= '0;
      m_ref <= '0;
      m_acc <= 0;
      m_ph  <= 0;
    end else if (m_ph == 0) begin
      if (b3.start) begin
        m_dut <= b3.tt_dut;
        m_ref <= b3.tt_ref;
        m_acc <= 0;
        m_ph  <= 1;
      end
    end else if (m_ph == 1) begin
      if (b3.row_ready) begin
        m_acc <= m_acc + 1;
        if (m_acc == 7) m_ph <= 2;
      end
    end else begin
      m_ph <= 0;
    end
  end

  // Every-cycle comparison of the N=3 instance against the model.
  always @(negedge clk) begin
    logic [7:0] mk;
    logic [7:0] dm;
    int ei;
    mk = mask(m_acc);
    dm = (m_dut ^ m_ref) & mk;
    ei = (m_acc > 7) ? 7 : m_acc;
    chk("busy", 32'(b3.busy), 32'(m_ph != 0));
    chk("row_valid", 32'(b3.row_valid), 32'(m_ph == 1));
    chk("done", 32'(b3.done), 32'(m_ph == 2));
    chk("row_idx", 32'(b3.row_idx), ei);
    chk("row_s", 32'(b3.row_s), 32'(m_dut[ei]));
    chk("row_ref", 32'(b3.row_ref), 32'(m_ref[ei]));
    chk("ones", 32'(b3.ones_count), popc(m_dut & mk));
    chk("mism", 32'(b3.mismatch_count), popc(dm));
    chk("first_mm", 32'(b3.first_mm_idx), lowest(dm));
    chk("any_mm", 32'(b3.any_mismatch), 32'(dm != 0));
  end

  task automatic sweep3(input logic [7:0] d, input logic [7:0] r,
                        input int stall_at, input int stall_n,
                        input int mid_start, output int cyc);
    int stalled = 0;
    bit injected = 0;
    b3.tt_dut = d;
    b3.tt_ref = r;
    b3.row_ready = 1'b1;
    b3.start = 1'b1;
    @(posedge clk); #1;
    b3.start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      if (mid_start >= 0 && !injected && b3.row_valid &&
          int'(b3.row_idx) == mid_start) begin
        b3.start = 1'b1;
        b3.tt_dut = ~d;
        b3.tt_ref = 8'h0F;
        injected = 1;
      end else begin
        b3.start = 1'b0;
      end
      if (stall_at >= 0 && b3.row_valid &&
          int'(b3.row_idx) == stall_at && stalled < stall_n) begin
        b3.row_ready = 1'b0;
        stalled++;
      end else begin
        b3.row_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (b3.done) break;
    end
    b3.start = 1'b0;
    b3.row_ready = 1'b1;
    if (!b3.done) chk("sweep_timeout", 32'(b3.done), 32'd1);
  endtask

  initial begin
    int cyc;
    int n;
    b3.start = 0; b3.tt_dut = '0; b3.tt_ref = '0; b3.row_ready = 1;
    b1.start = 0; b1.tt_dut = '0; b1.tt_ref = '0; b1.row_ready = 1;
    b4.start = 0; b4.tt_dut = '0; b4.tt_ref = '0; b4.row_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b3.busy), 0);
    chk("rst_ones", 32'(b3.ones_count), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ~z&(x|y): minterms 2,4,6
    sweep3(8'h54, 8'h54, -1, 0, -1, cyc);
    chk("t1_cyc", cyc, 8);
    chk("t1_ones", 32'(b3.ones_count), 3);
    chk("t1_mm", 32'(b3.mismatch_count), 0);
    chk("t1_any", 32'(b3.any_mismatch), 0);
    chk("t1_idx", 32'(b3.row_idx), 7);
    repeat (2) @(posedge clk); #1;
    chk("t1_hold", 32'(b3.ones_count), 3);

    sweep3(8'h54, 8'h55, -1, 0, -1, cyc);
    chk("t2_mm", 32'(b3.mismatch_count), 1);
    chk("t2_first", 32'(b3.first_mm_idx), 0);
    chk("t2_any", 32'(b3.any_mismatch), 1);
    chk("t2_ones", 32'(b3.ones_count), 3);
    @(posedge clk); #1;

    sweep3(8'h00, 8'hFF, -1, 0, -1, cyc);
    chk("t3_mm", 32'(b3.mismatch_count), 8);
    chk("t3_first", 32'(b3.first_mm_idx), 0);
    chk("t3_ones", 32'(b3.ones_count), 0);
    @(posedge clk); #1;

    sweep3(8'h54, 8'h54, 4, 3, -1, cyc);
    chk("t4_cyc", cyc, 11);
    chk("t4_ones", 32'(b3.ones_count), 3);
    @(posedge clk); #1;

    sweep3(8'h54, 8'h54, -1, 0, 3, cyc);
    chk("t5_cyc", cyc, 8);
    chk("t5_ones", 32'(b3.ones_count), 3);
    chk("t5_mm", 32'(b3.mismatch_count), 0);
    @(posedge clk); #1;

    // abort mid-sweep at row 5
    b3.tt_dut = 8'h54; b3.tt_ref = 8'h54; b3.start = 1;
    @(posedge clk); #1;
    b3.start = 0;
    n = 0;
    while (b3.row_idx != 3'd5 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_reach5", 32'(b3.row_idx), 5);
    chk("t5_ones5", 32'(b3.ones_count), 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(b3.busy), 0);
    chk("ar_valid", 32'(b3.row_valid), 0);
    chk("ar_idx", 32'(b3.row_idx), 0);
    chk("ar_ones", 32'(b3.ones_count), 0);
    chk("ar_done", 32'(b3.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("ar_nodone", 32'(b3.done), 0);
    sweep3(8'h54, 8'h54, -1, 0, -1, cyc);
    chk("ar_cyc", cyc, 8);
    chk("ar_ones_after", 32'(b3.ones_count), 3);

    // N=1
    b1.tt_dut = 2'b10; b1.tt_ref = 2'b10; b1.start = 1;
    @(posedge clk); #1;
    b1.start = 0;
    cyc = 0;
    while (!b1.done && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("n1_cyc", cyc, 2);
    chk("n1_ones", 32'(b1.ones_count), 1);
    chk("n1_mm", 32'(b1.mismatch_count), 0);
    chk("n1_idx", 32'(b1.row_idx), 1);

    // N=4: popcount(A5C3)=8, ref differs at bit 8
    b4.tt_dut = 16'hA5C3; b4.tt_ref = 16'hA4C3; b4.start = 1;
    @(posedge clk); #1;
    b4.start = 0;
    cyc = 0;
    while (!b4.done && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("n4_cyc", cyc, 16);
    chk("n4_ones", 32'(b4.ones_count), 8);
    chk("n4_mm", 32'(b4.mismatch_count), 1);
    chk("n4_first", 32'(b4.first_mm_idx), 8);
    chk("n4_idx", 32'(b4.row_idx), 15);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
